mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_arb_pkg.sv | 16 +
 rtl/mem_port_arbiter.sv | 167 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default sizing for the two-requester memory port arbiter.
package mem_arb_pkg;

  // Ownership of the single memory port.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } owner_t;

  localparam int DEF_ADDR_WIDTH = 16;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_BURST_MAX  = 8;
  localparam int STALL_CNT_W    = 16;

endpackage

// File: rtl/mem_port_arbiter.sv
// Two-requester (A: accelerator, B: UART controller) arbiter in front of one
// synchronous memory port with 1-cycle read latency.
// Ownership FSM with round-robin tie break and a burst limit: once the owner
// has taken BURST_MAX grants while the other side waits, the port drops to
// IDLE for one cycle and is handed to the waiting side.
// Optional macro ARB_STATS_EN adds saturating per-requester stall counters.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BURST_MAX  = DEF_BURST_MAX
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  a_en,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_dw,
  output logic                  a_gnt,
  output logic [DATA_WIDTH-1:0] a_dr,
  output logic                  a_rvalid,
  input  logic                  b_en,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_dw,
  output logic                  b_gnt,
  output logic [DATA_WIDTH-1:0] b_dr,
  output logic                  b_rvalid,
`ifdef ARB_STATS_EN
  output logic [STALL_CNT_W-1:0] a_stall_cnt,
  output logic [STALL_CNT_W-1:0] b_stall_cnt,
`endif
  output logic                  m_en,
  output logic                  m_we,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [DATA_WIDTH-1:0] m_dw,
  input  logic [DATA_WIDTH-1:0] m_dr
);

  localparam int CNT_W = (BURST_MAX < 2) ? 1 : $clog2(BURST_MAX + 1);
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(BURST_MAX - 1);

  owner_t           state;
  logic             last_b;     // 1: B owned the port most recently
  logic [CNT_W-1:0] burst_cnt;  // grants taken by the owner while the other waits
  logic             a_rd_pend;
  logic             b_rd_pend;

  // Grants are purely a function of the registered owner and the live request.
  assign a_gnt = a_en && (state == OWN_A);
  assign b_gnt = b_en && (state == OWN_B);

  // Ownership FSM: round-robin from IDLE, hand-over on drop, burst limit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      last_b    <= 1'b0;
      burst_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          burst_cnt <= '0;
          if (a_en && (!b_en || last_b)) begin
            state  <= OWN_A;
            last_b <= 1'b0;
          end else if (b_en) begin
            state  <= OWN_B;
            last_b <= 1'b1;
          end
        end
        OWN_A: begin
          if (!a_en) begin
            burst_cnt <= '0;
            if (b_en) begin
              state  <= OWN_B;
              last_b <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else if (b_en) begin
            // Only grants taken while B is waiting count toward the burst.
            if (burst_cnt == BURST_LAST) begin
              state     <= IDLE;
              burst_cnt <= '0;
            end else begin
              burst_cnt <= burst_cnt + 1'b1;
            end
          end
        end
        OWN_B: begin
          if (!b_en) begin
            burst_cnt <= '0;
            if (a_en) begin
              state  <= OWN_A;
              last_b <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end else if (a_en) begin
            if (burst_cnt == BURST_LAST) begin
              state     <= IDLE;
              burst_cnt <= '0;
            end else begin
              burst_cnt <= burst_cnt + 1'b1;
            end
          end
        end
        default: begin
          state     <= IDLE;
          burst_cnt <= '0;
        end
      endcase
    end
  end

  // Memory port mux: owner's request when granted, all zeros otherwise.
  always_comb begin
    m_en   = 1'b0;
    m_we   = 1'b0;
    m_addr = '0;
    m_dw   = '0;
    if (a_gnt) begin
      m_en   = 1'b1;
      m_we   = a_we;
      m_addr = a_addr;
      m_dw   = a_dw;
    end else if (b_gnt) begin
      m_en   = 1'b1;
      m_we   = b_we;
      m_addr = b_addr;
      m_dw   = b_dw;
    end
  end

  // Track granted reads so read data is flagged one cycle later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_rd_pend <= 1'b0;
      b_rd_pend <= 1'b0;
    end else begin
      a_rd_pend <= a_gnt && !a_we;
      b_rd_pend <= b_gnt && !b_we;
    end
  end

  assign a_rvalid = a_rd_pend;
  assign b_rvalid = b_rd_pend;
  assign a_dr     = a_rd_pend ? m_dr : '0;
  assign b_dr     = b_rd_pend ? m_dr : '0;

`ifdef ARB_STATS_EN
  // Saturating count of cycles each requester waited without a grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_stall_cnt <= '0;
      b_stall_cnt <= '0;
    end else begin
      if (a_en && !a_gnt && (a_stall_cnt != {STALL_CNT_W{1'b1}}))
        a_stall_cnt <= a_stall_cnt + 1'b1;
      if (b_en && !b_gnt && (b_stall_cnt != {STALL_CNT_W{1'b1}}))
        b_stall_cnt <= b_stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (default parameters).
module tb_mem_port_arbiter;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int BM = 8;

  logic          clk;
  logic          reset;
  logic          a_en, a_we, b_en, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_dw, b_dw;
  logic          a_gnt, b_gnt, a_rvalid, b_rvalid;
  logic [DW-1:0] a_dr, b_dr;
  logic          m_en, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_dw, m_dr;
`ifdef ARB_STATS_EN
  logic [15:0]   a_stall_cnt, b_stall_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_MAX(BM)) dut (
    .clk(clk), .reset(reset),
    .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_dw(a_dw),
    .a_gnt(a_gnt), .a_dr(a_dr), .a_rvalid(a_rvalid),
    .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_dw(b_dw),
    .b_gnt(b_gnt), .b_dr(b_dr), .b_rvalid(b_rvalid),
`ifdef ARB_STATS_EN
    .a_stall_cnt(a_stall_cnt), .b_stall_cnt(b_stall_cnt),
`endif
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_dw(m_dw), .m_dr(m_dr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after input changes.
  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    a_en = 0; a_we = 0; a_addr = '0; a_dw = '0;
    b_en = 0; b_we = 0; b_addr = '0; b_dw = '0;
  endtask

  // Every output must read zero.
  task automatic chk_all_zero(input string tag);
    chk({tag, ".gnt"},    {a_gnt, b_gnt}, 2'b00);
    chk({tag, ".rvalid"}, {a_rvalid, b_rvalid}, 2'b00);
    chk({tag, ".a_dr"},   a_dr, '0);
    chk({tag, ".b_dr"},   b_dr, '0);
    chk({tag, ".m_ctl"},  {m_en, m_we}, 2'b00);
    chk({tag, ".m_addr"}, m_addr, '0);
    chk({tag, ".m_dw"},   m_dw, '0);
  endtask

  initial begin
    logic [1:0] exp_g;
    int j;

    idle_inputs();
    m_dr  = 32'hDEAD_BEEF;
    reset = 1'b1;
    a_en  = 1'b1;        // request during reset must not be served
    a_addr = 16'h0055;
    settle();
    chk_all_zero("rst");
    step();
    chk_all_zero("rst_edge");

    // Single read from A.
    reset = 1'b0;
    idle_inputs();
    step();
    a_en = 1; a_we = 0; a_addr = 16'h0010;
    settle();
    chk("rd.c1_gnt", {a_gnt, b_gnt}, 2'b00);
    step();
    chk("rd.c2_gnt", {a_gnt, b_gnt}, 2'b10);
    chk("rd.c2_m",   {m_en, m_we}, 2'b10);
    chk("rd.c2_addr", m_addr, 16'h0010);
    chk("rd.c2_rv",  a_rvalid, 1'b0);
    step();
    a_en = 0;
    settle();
    chk("rd.c3_rv",  {a_rvalid, b_rvalid}, 2'b10);
    chk("rd.c3_dr",  a_dr, 32'hDEAD_BEEF);
    chk("rd.c3_bdr", b_dr, '0);
    chk("rd.c3_men", m_en, 1'b0);
    step();
    chk("rd.c4_rv",  a_rvalid, 1'b0);
    chk("rd.c4_dr",  a_dr, '0);

    // Both request after reset: B first, A after one idle cycle.
    reset = 1'b1;
    settle();
    reset = 1'b0;
    a_en = 1; a_addr = 16'h00A0;
    b_en = 1; b_addr = 16'h00B0;
    settle();
    chk("rr.idle", {a_gnt, b_gnt}, 2'b00);
    step();
    chk("rr.b1", {a_gnt, b_gnt}, 2'b01);
    chk("rr.b1_addr", m_addr, 16'h00B0);
    step();
    chk("rr.b2", {a_gnt, b_gnt}, 2'b01);
    step();
    b_en = 0;
    settle();
    chk("rr.gap", {a_gnt, b_gnt}, 2'b00);
    chk("rr.gap_brv", b_rvalid, 1'b1);
    step();
    chk("rr.a1", {a_gnt, b_gnt}, 2'b10);
    chk("rr.a1_addr", m_addr, 16'h00A0);
    step();
    a_en = 0;
    step();
    step();

    // Continuous contention: IDLE, 8xB, gap, 8xA, gap, 8xB, ...
    a_en = 1; a_we = 1; b_en = 1; b_we = 1;
    for (int i = 0; i < 40; i++) begin
      settle();
      if (i == 0) begin
        exp_g = 2'b00;
      end else begin
        j = i - 1;
        if (j % (BM + 1) == BM) exp_g = 2'b00;
        else if ((j / (BM + 1)) % 2 == 0) exp_g = 2'b01;
        else exp_g = 2'b10;
      end
      chk($sformatf("burst.c%0d", i), {a_gnt, b_gnt}, exp_g);
      step();
    end
    idle_inputs();
    step();
    step();

    // B write with A idle: no read data returned.
    b_en = 1; b_we = 1; b_addr = 16'h0003; b_dw = 32'h0000_1234;
    settle();
    chk("wr.idle", b_gnt, 1'b0);
    step();
    chk("wr.gnt",  {a_gnt, b_gnt}, 2'b01);
    chk("wr.m",    {m_en, m_we}, 2'b11);
    chk("wr.addr", m_addr, 16'h0003);
    chk("wr.dw",   m_dw, 32'h0000_1234);
    step();
    idle_inputs();
    settle();
    chk("wr.rv", {a_rvalid, b_rvalid}, 2'b00);
    step();

    // Burst counter holds while B is idle: A keeps 8 grants after B joins.
    a_en = 1; a_we = 1;
    step();
    for (int i = 0; i < 12; i++) step();
    settle();
    chk("hold.solo", {a_gnt, b_gnt}, 2'b10);
    b_en = 1; b_we = 1;
    for (int i = 0; i < BM; i++) begin
      settle();
      chk($sformatf("hold.a%0d", i), {a_gnt, b_gnt}, 2'b10);
      step();
    end
    settle();
    chk("hold.gap", {a_gnt, b_gnt}, 2'b00);
    step();
    chk("hold.b", {a_gnt, b_gnt}, 2'b01);
    idle_inputs();
    step();
    step();

    // Reset right after a granted read: pending read data is dropped.
    m_dr = 32'hCAFE_F00D;
    a_en = 1; a_we = 0; a_addr = 16'h0020;
    step();
    chk("rrst.gnt", a_gnt, 1'b1);
    step();
    a_en = 0;
    reset = 1'b1;
    settle();
    chk_all_zero("rrst.in");
    step();
    reset = 1'b0;
    settle();
    chk_all_zero("rrst.after");

`ifdef ARB_STATS_EN
    // A blocked one IDLE cycle plus four B grants.
    reset = 1'b1;
    settle();
    reset = 1'b0;
    chk("stat.rst", a_stall_cnt, 16'd0);
    a_en = 1; b_en = 1; a_we = 1; b_we = 1;
    for (int i = 0; i < 5; i++) step();
    idle_inputs();
    settle();
    chk("stat.a5", a_stall_cnt, 16'd5);
    chk("stat.b1", b_stall_cnt, 16'd1);
    step();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
